// File: rtl/call_stack_pkg.sv
// Shared CPU package: call-stack geometry, reset address and stack-operation decode.
package call_stack_pkg;

    localparam int CS_WIDTH = 10;
    localparam int CS_DEPTH = 8;
    localparam int CS_PTR_W = $clog2(CS_DEPTH);
    localparam logic [CS_WIDTH-1:0] CS_RESET_ADDR = '0;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

    // Push and pop together replace the top entry instead of moving the pointer.
    function automatic stack_op_e decode_op(input logic en, input logic push, input logic pop);
        stack_op_e op;
        op = OP_IDLE;
        if (en) begin
            case ({push, pop})
                2'b10:   op = OP_PUSH;
                2'b01:   op = OP_POP;
                2'b11:   op = OP_SWAP;
                default: op = OP_IDLE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/call_stack_if.sv
// Control/data bundle between the program-counter controller and the return-address stack.
// Sticky overflow/underflow signals exist only when CALL_STACK_FLAGS_EN is defined.
interface call_stack_if
    import call_stack_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH,
    parameter int DEPTH = CS_DEPTH
);

    logic                     en;
    logic                     push;
    logic                     pop;
    logic [WIDTH-1:0]         IN_PC;
    logic [WIDTH-1:0]         OUT_PC;
    logic [$clog2(DEPTH):0]   level;
    logic                     full;
    logic                     empty;
`ifdef CALL_STACK_FLAGS_EN
    logic                     overflow;
    logic                     underflow;
`endif

    modport master (
        output en,
        output push,
        output pop,
        output IN_PC,
        input  OUT_PC,
        input  level,
        input  full,
`ifdef CALL_STACK_FLAGS_EN
        input  overflow,
        input  underflow,
`endif
        input  empty
    );

    modport slave (
        input  en,
        input  push,
        input  pop,
        input  IN_PC,
        output OUT_PC,
        output level,
        output full,
`ifdef CALL_STACK_FLAGS_EN
        output overflow,
        output underflow,
`endif
        output empty
    );

endinterface

// File: rtl/call_stack.sv
// Circular return-address stack with combinational top-of-stack read and resettable register storage.
// Optional sticky overflow/underflow flags are built only when CALL_STACK_FLAGS_EN is defined.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH,
    parameter int DEPTH = CS_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    call_stack_if.slave bus
);

    localparam int          PW        = $clog2(DEPTH);
    localparam logic [PW:0] LEVEL_MAX = (PW+1)'(DEPTH);

    stack_op_e        op;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    ptr_next;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic [PW:0]      level_reg;
    logic [PW:0]      level_next;
    logic             wr_en;
    logic             full;
    logic             empty;

    assign op      = decode_op(bus.en, bus.push, bus.pop);
    assign top_idx = ptr_reg - PW'(1);
    assign full    = (level_reg == LEVEL_MAX);
    assign empty   = (level_reg == '0);

    // The pointer always wraps; only level saturates, so a full push drops the oldest entry.
    always_comb begin
        ptr_next   = ptr_reg;
        level_next = level_reg;
        wr_en      = 1'b0;
        wr_idx     = ptr_reg;
        case (op)
            OP_PUSH: begin
                wr_en    = 1'b1;
                ptr_next = ptr_reg + PW'(1);
                if (!full) begin
                    level_next = level_reg + (PW+1)'(1);
                end
            end
            OP_POP: begin
                ptr_next = top_idx;
                if (!empty) begin
                    level_next = level_reg - (PW+1)'(1);
                end
            end
            OP_SWAP: begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= WIDTH'(CS_RESET_ADDR);
            end
            ptr_reg   <= '0;
            level_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            level_reg <= level_next;
            if (wr_en) begin
                mem_reg[wr_idx] <= bus.IN_PC;
            end
        end
    end

    assign bus.OUT_PC = mem_reg[top_idx];
    assign bus.level  = level_reg;
    assign bus.full   = full;
    assign bus.empty  = empty;

`ifdef CALL_STACK_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (op == OP_PUSH && full) begin
                overflow_reg <= 1'b1;
            end
            if (op == OP_POP && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
`endif

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 10, return-address width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of stack entries; power of two.
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  global advance; when low, no state changes.
REQ-006 SHALL have port push  input  1  write IN_PC onto the stack at this edge.
REQ-007 SHALL have port pop  input  1  remove the top entry at this edge.
REQ-008 SHALL have port IN_PC  input  WIDTH  return address from the program counter.
REQ-009 SHALL have port OUT_PC  output  WIDTH  current top entry, to the program counter.
REQ-010 SHALL have port level  output  log2(DEPTH)+1  valid entry count, 0..DEPTH.
REQ-011 SHALL have ports full and empty  output  1 each  level==DEPTH and level==0.
REQ-012 SHALL have ports overflow and underflow  output  1 each  sticky error flags, present only per REQ-027.

Function
REQ-013 SHALL hold DEPTH x WIDTH entries and a write pointer ptr of log2(DEPTH) bits.
REQ-014 SHALL drive OUT_PC combinationally as mem[ptr-1 mod DEPTH]; zero latency, so the value is valid before the pop edge.
REQ-015 SHALL, on push only (en=1), write IN_PC to mem[ptr] and set ptr to ptr+1 mod DEPTH.
REQ-016 SHALL, on pop only (en=1), set ptr to ptr-1 mod DEPTH; memory unchanged.
REQ-017 SHALL, on push and pop together (en=1), overwrite mem[ptr-1] with IN_PC, leave ptr and level unchanged, and drive the old top on OUT_PC before the edge.
REQ-018 SHALL increment level on push-only when not full and decrement it on pop-only when not empty.
REQ-019 SHALL, on push-only when full, wrap ptr and overwrite the oldest entry, with level saturated at DEPTH (circular stack).
REQ-020 SHALL, on pop-only when empty, still wrap ptr down, with level held at 0 and OUT_PC showing the stale wrapped entry.
REQ-021 SHALL ignore push and pop while en=0, matching the program counter's stall.
REQ-022 SHALL sample IN_PC at the push edge; control asserts push one cycle after the program counter's call_en, once the return address is registered.

Reset
REQ-023 SHALL, while reset=0, immediately clear ptr, level and all memory entries to 0, independent of clock.
REQ-024 SHALL therefore show, during and after reset, OUT_PC=0, level=0, empty=1, full=0, and overflow=underflow=0 when present.
REQ-025 SHALL abandon any push or pop coinciding with reset assertion; no partial write.
REQ-026 SHALL resume operation on the first rising edge after reset returns high.

Configuration
REQ-027 SHALL compile overflow/underflow ports and logic only when macro CALL_STACK_FLAGS_EN is defined. When defined: overflow sets on push-only while full, underflow sets on pop-only while empty, and both clear only by reset. When undefined: the ports are absent and there is no flag logic; push/pop behaviour is unchanged.

Structure
REQ-028 SHALL place WIDTH/DEPTH defaults, the log2 pointer width and the reset address constant (0) in the shared CPU package used by the program counter.
REQ-029 SHALL be a single module with no sub-module; memory is a register array, not an inferred RAM, because reset clears it.

Verification
REQ-030 Reset low mid-run with level=3 -> OUT_PC=0, level=0, empty=1 without a clock edge.
REQ-031 Push 0x005, 0x0A0, 0x3FF, then pop x3 -> OUT_PC reads 0x3FF, 0x0A0, 0x005 before each pop; ends with level=0 and empty=1.
REQ-032 Push 9 values 0x001..0x009 (DEPTH=8) -> level=8, full=1, OUT_PC=0x009; 8 pops return 0x009..0x002; overflow=1 if flags enabled.
REQ-033 Pop on empty after reset -> level stays 0; underflow=1 if flags enabled, else no flag ports exist.
REQ-034 level=2, top 0x010, push 0x020 with pop in the same cycle -> OUT_PC=0x010 before the edge, then 0x020 with level=2.
REQ-035 en=0 with push=1 and IN_PC=0x123 -> level and OUT_PC unchanged; after en=1 the push takes effect.
